pipe_slice: RTL and testbench

Parametrised pipeline register slice with a valid/ready handshake and a 2-entry skid buffer. It is the successor to the plain enable/reset flops used between core pipeline stages. It adds backpressure, a registered in_ready that breaks the combinational ready path, a synchronous flush for branch/exception squash, and an occupancy count. It sustains one transfer per cycle and has a fixed one-cycle forward latency.

---
 rtl/pipe_slice.sv | 72 +++++++
 tb/tb_pipe_slice.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_slice.sv
`default_nettype none
// ============================================================================
// pipe_slice : valid/ready pipeline register slice with a 2-entry skid buffer,
//              registered in_ready, synchronous flush and occupancy count.
// Revision   : 1.0
// ============================================================================
module pipe_slice #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    // in_ready comes straight from the skid valid flop, so out_ready never
    // reaches it combinationally.
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    // skid_v implies main_v, so the sum reduces to these two bits.
    assign count     = {main_v & skid_v, main_v ^ skid_v};

    assign in_fire  = in_valid & ~skid_v;
    assign out_fire = main_v & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RESET_VAL;
            skid_d <= RESET_VAL;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is squashed.
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (out_fire) begin
                main_d <= skid_d;
                skid_v <= 1'b0;
            end
        end else if (main_v) begin
            if (in_fire && out_fire) begin
                main_d <= in_data;
            end else if (in_fire) begin
                skid_d <= in_data;
                skid_v <= 1'b1;
            end else if (out_fire) begin
                main_v <= 1'b0;
            end
        end else if (in_fire) begin
            main_d <= in_data;
            main_v <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_slice.sv
`default_nettype none
// ============================================================================
// tb_pipe_slice : directed vector table plus scoreboarded streaming/random
//                 traffic on three slice instances (WIDTH 32, 8 and 64).
// Revision      : 1.0
// ============================================================================
module tb_pipe_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        flush, iv, ir, ordy, ov;
    logic [31:0] id, od;
    logic [1:0]  cnt;
    logic        flush8, iv8, ir8, ordy8, ov8;
    logic [7:0]  id8, od8;
    logic [1:0]  cnt8;
    logic        flush64, iv64, ir64, ordy64, ov64;
    logic [63:0] id64, od64;
    logic [1:0]  cnt64;

    pipe_slice #(.WIDTH(32), .RESET_VAL(32'hDEADBEEF)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(iv), .in_ready(ir),
        .in_data(id), .out_valid(ov), .out_ready(ordy), .out_data(od), .count(cnt));
    pipe_slice #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .flush(flush8), .in_valid(iv8), .in_ready(ir8),
        .in_data(id8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .count(cnt8));
    pipe_slice #(.WIDTH(64)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush64), .in_valid(iv64), .in_ready(ir64),
        .in_data(id64), .out_valid(ov64), .out_ready(ordy64), .out_data(od64), .count(cnt64));

    int n_chk = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    // Per-instance scoreboard: entries accepted but not yet delivered.
    logic [63:0] sbq [3][$];
    bit          p_rn [3], p_fl [3], p_iv [3], p_ir [3], p_ov [3], p_ordy [3];
    logic [63:0] p_id [3], p_od [3];

    task automatic mon(input int k, input bit rn, input bit fl, input bit iv_,
                       input logic ir_, input logic [63:0] id_, input logic ov_,
                       input bit ordy_, input logic [63:0] od_, input logic [1:0] cnt_);
        int sz;
        sz = sbq[k].size();
        n_chk++;
        if (cnt_ !== 2'(sz) || ov_ !== (sz != 0) || ir_ !== (sz < 2) ||
            (sz != 0 && od_ !== sbq[k][0])) begin
            n_err++;
            $display("FAIL sb%0d_state t=%0t: count=%0d out_valid=%b in_ready=%b out_data=%h, want count=%0d out_valid=%b in_ready=%b out_data=%h",
                     k, $time, cnt_, ov_, ir_, od_, sz, sz != 0, sz < 2,
                     (sz != 0) ? sbq[k][0] : 64'h0);
        end
        if (p_rn[k] && !p_fl[k] && p_ov[k] && !p_ordy[k]) begin
            n_chk++;
            if (ov_ !== 1'b1 || od_ !== p_od[k]) begin
                n_err++;
                $display("FAIL sb%0d_stall t=%0t: out_valid=%b out_data=%h, want 1 %h",
                         k, $time, ov_, od_, p_od[k]);
            end
        end
        if (p_rn[k] && !p_fl[k] && p_iv[k] && !p_ir[k]) begin
            n_chk++;
            if (!iv_ || id_ !== p_id[k]) begin
                n_err++;
                $display("FAIL sb%0d_upstream t=%0t: in_valid=%b in_data=%h, want 1 %h",
                         k, $time, iv_, id_, p_id[k]);
            end
        end
        if (!rn) begin
            sbq[k].delete();
        end else begin
            if (ov_ === 1'b1 && ordy_ && sbq[k].size() != 0) void'(sbq[k].pop_front());
            if (fl) sbq[k].delete();
            else if (iv_ && ir_ === 1'b1) sbq[k].push_back(id_);
        end
        p_rn[k] = rn;  p_fl[k] = fl;  p_iv[k] = iv_;  p_ir[k] = (ir_ === 1'b1);
        p_ov[k] = (ov_ === 1'b1);  p_ordy[k] = ordy_;  p_id[k] = id_;  p_od[k] = od_;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, rstn, flush,   iv,   ir,   64'(id),   ov,   ordy,   64'(od),   cnt);
            mon(1, rstn, flush8,  iv8,  ir8,  64'(id8),  ov8,  ordy8,  64'(od8),  cnt8);
            mon(2, rstn, flush64, iv64, ir64, id64,      ov64, ordy64, od64,      cnt64);
        end
    end

    typedef struct {
        bit          rn, fl, iv;
        logic [31:0] id;
        bit          ordy;
        bit          e_ov;
        logic [31:0] e_od;
        bit          e_ir;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(bit rn, bit fl, bit iv_, logic [31:0] id_, bit ordy_,
                                bit e_ov, logic [31:0] e_od, bit e_ir, logic [1:0] e_cnt);
        vec_t v;
        v.rn = rn; v.fl = fl; v.iv = iv_; v.id = id_; v.ordy = ordy_;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl [19];
    bit   fire8, fire64, pf8, pf64;

    initial begin
        // Expected outputs are those visible just after the edge that applies each row.
        tbl[0]  = mk(0,0,0,32'h0, 0, 0,32'hDEADBEEF,1,0);
        tbl[1]  = mk(1,0,1,32'hA, 0, 1,32'hA,1,1);
        tbl[2]  = mk(1,0,1,32'hB, 0, 1,32'hA,0,2);
        tbl[3]  = mk(1,0,1,32'hC, 0, 1,32'hA,0,2);
        tbl[4]  = mk(1,0,1,32'hC, 1, 1,32'hB,1,1);
        tbl[5]  = mk(1,0,1,32'hC, 1, 1,32'hC,1,1);
        tbl[6]  = mk(1,0,0,32'h0, 1, 0,32'hC,1,0);
        tbl[7]  = mk(1,0,1,32'h11,0, 1,32'h11,1,1);
        tbl[8]  = mk(1,0,1,32'h22,0, 1,32'h11,0,2);
        tbl[9]  = mk(1,1,1,32'h33,0, 0,32'h11,1,0);
        tbl[10] = mk(1,0,0,32'h0, 1, 0,32'h11,1,0);
        tbl[11] = mk(1,0,1,32'h5, 0, 1,32'h5,1,1);
        tbl[12] = mk(1,0,1,32'h6, 1, 1,32'h6,1,1);
        tbl[13] = mk(1,0,0,32'h0, 0, 1,32'h6,1,1);
        tbl[14] = mk(1,0,1,32'h7, 0, 1,32'h6,0,2);
        tbl[15] = mk(0,0,0,32'h0, 0, 0,32'hDEADBEEF,1,0);
        tbl[16] = mk(1,0,1,32'h8, 0, 1,32'h8,1,1);
        tbl[17] = mk(1,1,1,32'h9, 1, 0,32'h8,1,0);
        tbl[18] = mk(1,0,0,32'h0, 0, 0,32'h8,1,0);

        rstn = 1'b0; flush = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;
        flush8 = 1'b0; iv8 = 1'b0; id8 = '0; ordy8 = 1'b0;
        flush64 = 1'b0; iv64 = 1'b0; id64 = '0; ordy64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;

        for (int i = 0; i < 19; i++) begin
            rstn = tbl[i].rn; flush = tbl[i].fl; iv = tbl[i].iv;
            id = tbl[i].id; ordy = tbl[i].ordy;
            @(posedge clk);
            #1;
            n_chk++;
            if (ov !== tbl[i].e_ov || od !== tbl[i].e_od || ir !== tbl[i].e_ir ||
                cnt !== tbl[i].e_cnt) begin
                n_err++;
                $display("FAIL vec%0d: out_valid=%b out_data=%h in_ready=%b count=%0d, want %b %h %b %0d",
                         i, ov, od, ir, cnt, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ir, tbl[i].e_cnt);
            end
        end
        rstn = 1'b1; flush = 1'b0;

        // Back-to-back streaming with a permanently ready sink.
        for (int i = 1; i <= 16; i++) begin
            iv = 1'b1; id = 32'(i); ordy = 1'b1;
            @(posedge clk);
            #1;
            n_chk++;
            if (ov !== 1'b1 || od !== 32'(i) || ir !== 1'b1 || cnt !== 2'd1) begin
                n_err++;
                $display("FAIL stream%0d: out_valid=%b out_data=%h in_ready=%b count=%0d, want 1 %h 1 1",
                         i, ov, od, ir, cnt, 32'(i));
            end
        end
        iv = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (ov !== 1'b0 || cnt !== 2'd0) begin
            n_err++;
            $display("FAIL stream_drain: out_valid=%b count=%0d, want 0 0", ov, cnt);
        end

        // Random traffic on the 8- and 64-bit instances, protocol-respecting upstream.
        fire8 = 1'b0; fire64 = 1'b0; pf8 = 1'b0; pf64 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!(iv8 && !fire8 && !pf8)) begin
                iv8 = 1'($urandom_range(0, 1));
                id8 = 8'($urandom);
            end
            if (!(iv64 && !fire64 && !pf64)) begin
                iv64 = 1'($urandom_range(0, 1));
                id64 = {$urandom, $urandom};
            end
            ordy8   = 1'($urandom_range(0, 1));
            ordy64  = 1'($urandom_range(0, 1));
            flush8  = ($urandom_range(0, 99) == 0);
            flush64 = ($urandom_range(0, 99) == 0);
            fire8  = iv8 & ir8;
            fire64 = iv64 & ir64;
            pf8  = flush8;
            pf64 = flush64;
            @(posedge clk);
            #1;
        end
        iv8 = 1'b0; iv64 = 1'b0; ordy8 = 1'b1; ordy64 = 1'b1;
        flush8 = 1'b0; flush64 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_chk++;
        if (ov8 !== 1'b0 || ov64 !== 1'b0 || cnt8 !== 2'd0 || cnt64 !== 2'd0) begin
            n_err++;
            $display("FAIL random_drain: out_valid8=%b out_valid64=%b count8=%0d count64=%0d, want 0 0 0 0",
                     ov8, ov64, cnt8, cnt64);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
